// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq -- sequential binary-to-BCD converter (double-dabble)
//
// Converts an unsigned WIDTH-bit value into DIGITS packed BCD digits. The
// converter processes one input bit per clock. The result register keeps the
// last completed conversion, so the seven-segment decoders downstream never
// see a partial value.
//
// Parameters:
//   WIDTH  - bit width of the unsigned binary input (default 8)
//   DIGITS - number of BCD digits produced (default 3). The integrator must
//            ensure 10**DIGITS > 2**WIDTH - 1. There is no overflow check.
//
// Ports:
//   clock  in   1          rising-edge clock
//   reset  in   1          asynchronous active-high reset
//   start  in   1          conversion request, sampled only while busy = 0
//   bin    in   WIDTH      binary value, captured on the accepting edge
//   busy   out  1          high while a conversion is in flight
//   done   out  1          one-cycle pulse, bcd was updated on this edge
//   bcd    out  4*DIGITS   packed result, digit k at bits [4k+3:4k]
//
// Optional build macro:
//   BIN2BCD_BLANK_EN - leading-zero blanking. Every digit above the most
//                      significant nonzero digit is written as 4'hF, which
//                      the downstream decoder shows as blank. Digit 0 is never
//                      blanked. The reset value of bcd becomes 0 in digit 0
//                      and 4'hF in every higher digit. Latency is unchanged.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW    = 4 * DIGITS;
  localparam int WW    = BW + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef BIN2BCD_BLANK_EN
  // Blanked reset pattern: digit 0 shows 0, all higher digits blank.
  localparam logic [BW-1:0] BCD_RST = {BW{1'b1}} << 4;
`else
  localparam logic [BW-1:0] BCD_RST = '0;
`endif

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;

  // Scratch BCD digits and the binary shift register live in one combined
  // register: upper BW bits are the scratch digits, lower WIDTH bits are the
  // remaining binary input. A single left shift moves the input MSB straight
  // into the scratch LSB.
  logic [WW-1:0]    work;
  logic [CNT_W-1:0] count;

  logic [BW-1:0]    adjusted;
  logic [WW-1:0]    work_next;
  logic [BW-1:0]    result;

  // ---------------------------------------------------------------------------
  // Add-3 correction: every scratch digit >= 5 gets +3 before the shift.
  // 4-bit arithmetic is enough; a corrected digit cannot carry into its
  // neighbour, the shift provides the only inter-digit carry.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign every always_comb output a default first, otherwise any
    // path that skips an assignment infers a latch.
    adjusted = work[WW-1 -: BW];
    for (int k = 0; k < DIGITS; k++) begin
      if (work[WIDTH + 4*k +: 4] >= 4'd5) begin
        adjusted[4*k +: 4] = work[WIDTH + 4*k +: 4] + 4'd3;
      end
    end
  end

  // One double-dabble iteration: corrected digits plus binary, shifted left.
  assign work_next = {adjusted, work[WIDTH-1:0]} << 1;

  // ---------------------------------------------------------------------------
  // Result formatting stage, feeding the bcd register on the final iteration.
  // ---------------------------------------------------------------------------
`ifdef BIN2BCD_BLANK_EN
  logic lead_seen;

  always_comb begin
    result    = work_next[WW-1 -: BW];
    lead_seen = 1'b0;
    // Walk from the most significant digit down; digits are blanked until the
    // first nonzero one. Digit 0 is excluded so a zero value still shows "0".
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (work_next[WIDTH + 4*k +: 4] != 4'd0) begin
        lead_seen = 1'b1;
      end
      if (!lead_seen) begin
        result[4*k +: 4] = 4'hF;
      end
    end
  end
`else
  assign result = work_next[WW-1 -: BW];
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  //   IDLE : wait for start; latch bin and arm the bit counter.
  //   SHIFT: one iteration per edge; the edge where count is 0 performs the
  //          last iteration and publishes the result.
  // Accepting at E0 loads count = WIDTH-1, so edges E0+1 .. E0+WIDTH perform
  // the WIDTH iterations and done rises on edge E0+WIDTH.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= BCD_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      // done is a single-cycle pulse; cleared unless the final iteration
      // below re-asserts it.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            work  <= {{BW{1'b0}}, bin};
            count <= CNT_W'(WIDTH - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // start and bin are deliberately not looked at here: requests
          // during a conversion are dropped, not queued.
          work  <= work_next;
          count <= count - CNT_W'(1);
          if (count == '0) begin
            bcd   <= result;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq -- self-checking bench for bin2bcd_seq (WIDTH=8, DIGITS=3).
// Directed table of values with hand-computed BCD, hand-written sequences for
// the multi-cycle corner cases, then a full sweep against a decimal model.
// Honours BIN2BCD_BLANK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] exp_raw;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply leading-zero blanking to a raw 3-digit BCD value when enabled.
  function automatic logic [11:0] blank_fn(input logic [11:0] raw);
    logic [11:0] r;
    r = raw;
`ifdef BIN2BCD_BLANK_EN
    if (raw[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (raw[7:4] == 4'd0) r[7:4] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'(v / 100);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return blank_fn({d2, d1, d0});
  endfunction

  // Present a value with start for exactly one accepting edge; returns at the
  // falling edge following that accept.
  task automatic launch(input logic [7:0] b);
    @(negedge clock);
    bin   = b;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // From a falling edge, count rising edges until done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_hi);
    lat     = 0;
    busy_hi = 0;
    while (!done && lat < 20) begin
      if (busy) busy_hi++;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
  endtask

  task automatic run_conv(input logic [7:0] b, input logic [11:0] exp, input string name);
    int lat, busy_hi;
    launch(b);
    wait_done(lat, busy_hi);
    check({name, "_latency"}, lat, 8);
    check({name, "_busy_cycles"}, busy_hi, 8);
    check({name, "_busy_at_done"}, busy, 0);
    check({name, "_bcd"}, bcd, exp);
    @(posedge clock);
    @(negedge clock);
    check({name, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int lat, busy_hi, dcount, t1, t2;
    logic [11:0] rst_val;

    vecs[0]  = '{8'd0,   12'h000, "v0"};
    vecs[1]  = '{8'd255, 12'h255, "v255"};
    vecs[2]  = '{8'd99,  12'h099, "v99"};
    vecs[3]  = '{8'd1,   12'h001, "v1"};
    vecs[4]  = '{8'd9,   12'h009, "v9"};
    vecs[5]  = '{8'd10,  12'h010, "v10"};
    vecs[6]  = '{8'd100, 12'h100, "v100"};
    vecs[7]  = '{8'd128, 12'h128, "v128"};
    vecs[8]  = '{8'd200, 12'h200, "v200"};
    vecs[9]  = '{8'd7,   12'h007, "v7"};
    vecs[10] = '{8'd59,  12'h059, "v59"};
    vecs[11] = '{8'd205, 12'h205, "v205"};

    rst_val = blank_fn(12'h000);

    // Reset state
    reset = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, rst_val);
    reset = 1'b0;
    @(negedge clock);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].b, blank_fn(vecs[i].exp_raw), vecs[i].name);
    end

    // start pulsed during a conversion is ignored
    launch(8'd128);
    repeat (3) @(posedge clock);
    @(negedge clock);
    bin   = 8'd17;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    bin   = 8'd0;
    wait_done(lat, busy_hi);
    check("ign_latency_rest", lat, 4);
    check("ign_bcd", bcd, blank_fn(12'h128));
    dcount = 0;
    repeat (20) begin
      @(posedge clock);
      @(negedge clock);
      if (done) dcount++;
    end
    check("ign_no_second_done", dcount, 0);
    check("ign_idle_busy", busy, 0);
    check("ign_bcd_held", bcd, blank_fn(12'h128));

    // start held high: back-to-back conversions, new bin at the done cycle
    @(negedge clock);
    bin   = 8'd200;
    start = 1'b1;
    t1 = -1;
    for (int n = 0; n < 20 && t1 < 0; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) t1 = cyc;
    end
    check("hold_first_done_seen", (t1 >= 0), 1);
    check("hold_first_bcd", bcd, blank_fn(12'h200));
    bin = 8'd7;
    t2 = -1;
    for (int n = 0; n < 20 && t2 < 0; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) t2 = cyc;
    end
    start = 1'b0;
    check("hold_second_done_seen", (t2 >= 0), 1);
    check("hold_done_spacing", t2 - t1, 9);
    check("hold_second_bcd", bcd, blank_fn(12'h007));
    @(posedge clock);
    @(negedge clock);
    check("hold_stopped_busy", busy, 0);

    // Reset in the middle of a conversion
    launch(8'd255);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bcd", bcd, rst_val);
    @(negedge clock);
    reset = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(posedge clock);
      @(negedge clock);
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    check("midrst_bcd_after", bcd, rst_val);
    run_conv(8'd42, blank_fn(12'h042), "after_rst42");

    // Full sweep against the decimal model
    for (int v = 0; v < 256; v++) begin
      logic ok;
      run_conv(8'(v), ref_bcd(v), "sweep");
      ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (bcd[4*k +: 4] > 4'd9) begin
`ifdef BIN2BCD_BLANK_EN
          if (!(k > 0 && bcd[4*k +: 4] == 4'hF)) ok = 1'b0;
`else
          ok = 1'b0;
`endif
        end
      end
      check("sweep_digit_range", ok, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
